// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter: FSM states, mode
// encodings and a constant-width helper for index/counter sizing.
package bram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Never returns less than 1 so single-value indices still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Combinational winner selection: rotate requests so the search starts at the
// base index, take the lowest set bit, then rotate the index back.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    input  logic              mode,
    output logic [IDX_W-1:0]  winner,
    output logic              any_req
);

    logic [IDX_W-1:0]  w_base;
    logic [NUM_CH-1:0] w_rot;
    int                w_j;
    int                w_idx;
    int                w_win;

    // Fixed priority is round-robin with the search anchored at channel 0.
    assign w_base  = (mode == MODE_FIXED) ? '0 : rr_ptr;
    assign any_req = |req;

    always_comb begin
        w_rot  = '0;
        w_j    = 0;
        w_idx  = 0;
        w_win  = 0;
        winner = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_j = i + int'(w_base);
            if (w_j >= NUM_CH) w_j = w_j - NUM_CH;
            w_rot[i] = req[IDX_W'(w_j)];
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) w_idx = i;
        end
        w_win = w_idx + int'(w_base);
        if (w_win >= NUM_CH) w_win = w_win - NUM_CH;
        winner = IDX_W'(w_win);
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// N-channel request/grant arbiter in front of one BRAM port, with bounded
// bursts and read-valid routed back to the channel that issued the read.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        addr_bram,
    output logic                     en_bram,
    output logic                     we_bram,
    output logic [DATA_W-1:0]        din_bram,
    input  logic [DATA_W-1:0]        dout_bram
);

    localparam int IDX_W  = clog2(NUM_CH);
    localparam int BEAT_W = clog2(MAX_BURST + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_mode;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [NUM_CH-1:0] r_rd_pipe [RD_LAT];

    logic [IDX_W-1:0]  w_winner;
    logic [IDX_W-1:0]  w_owner_inc;
    logic              w_any_req;
    logic [BEAT_W-1:0] w_beat_inc;
    logic              w_access;
    logic              w_last;
    logic              w_leave;
    logic [NUM_CH-1:0] w_owner_oh;
    logic [NUM_CH-1:0] w_push;
    logic              w_sel_req;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .mode    (mode),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    always_comb begin
        w_owner_oh  = '0;
        w_sel_req   = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_owner_oh[i] = 1'b1;
                w_sel_req     = req[i];
                w_sel_we      = we[i];
                w_sel_addr    = addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata   = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        gnt       = '0;
        en_bram   = 1'b0;
        we_bram   = 1'b0;
        addr_bram = '0;
        din_bram  = '0;
        if (r_state == GRANT) begin
            gnt       = w_owner_oh;
            en_bram   = w_sel_req;
            we_bram   = w_sel_req & w_sel_we;
            addr_bram = w_sel_addr;
            din_bram  = w_sel_wdata;
        end
    end

    assign rdata       = dout_bram;
    assign w_access    = (r_state == GRANT) && w_sel_req;
    assign w_beat_inc  = r_beat_cnt + 1'b1;
    assign w_last      = w_access && (w_beat_inc == BEAT_W'(MAX_BURST));
    assign w_leave     = (r_state == GRANT) && (!w_sel_req || w_last);
    assign w_owner_inc = (r_owner == IDX_W'(NUM_CH - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = GRANT;
            GRANT:   if (w_leave) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Mode is latched at arbitration so a mid-grant change cannot move rr_ptr.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_mode     <= MODE_RR;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_any_req) begin
                r_owner    <= w_winner;
                r_mode     <= mode;
                r_beat_cnt <= '0;
            end
            if (w_access) r_beat_cnt <= w_beat_inc;
            if (w_leave && (r_mode == MODE_RR)) r_rr_ptr <= w_owner_inc;
        end
    end

    // Read-return tag pipeline: one-hot owner per read, zero otherwise.
    assign w_push = (en_bram && !we_bram) ? w_owner_oh : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < RD_LAT; k++) r_rd_pipe[k] <= '0;
        end else begin
            r_rd_pipe[0] <= w_push;
            for (int k = 1; k < RD_LAT; k++) r_rd_pipe[k] <= r_rd_pipe[k-1];
        end
    end

    assign rvalid = r_rd_pipe[RD_LAT-1];

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: per-cycle vector table plus
// hand-written round-robin, read-after-write and reset-mid-burst sequences.
module tb_bram_port_arbiter;

    logic         clk;
    logic         resetn;
    logic         mode;
    logic [3:0]   req;
    logic [35:0]  addr;
    logic [3:0]   we;
    logic [127:0] wdata;
    logic [3:0]   gnt;
    logic [3:0]   rvalid;
    logic [31:0]  rdata;
    logic [8:0]   addr_bram;
    logic         en_bram;
    logic         we_bram;
    logic [31:0]  din_bram;
    logic [31:0]  dout_bram;

    int n_checks = 0;
    int n_fail   = 0;

    bram_port_arbiter #(
        .NUM_CH(4), .ADDR_W(9), .DATA_W(32), .RD_LAT(2), .MAX_BURST(4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mode      (mode),
        .req       (req),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .addr_bram (addr_bram),
        .en_bram   (en_bram),
        .we_bram   (we_bram),
        .din_bram  (din_bram),
        .dout_bram (dout_bram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle-latency BRAM model.
    logic [31:0] mem [512];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (en_bram && we_bram) mem[addr_bram] <= din_bram;
        else if (en_bram) rd1 <= mem[addr_bram];
        dout_bram <= rd1;
    end

    typedef struct {
        logic       md;
        logic [3:0] rq;
        logic [3:0] w;
        logic [8:0] a;
        logic [3:0] e_gnt;
        logic       e_en;
        logic       e_we;
        logic [8:0] e_addr;
        logic [3:0] e_rv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic md, input logic [3:0] rq, input logic [3:0] w,
                                input logic [8:0] a, input logic [3:0] g, input logic e,
                                input logic wb, input logic [8:0] ea, input logic [3:0] rv);
        vec_t v;
        v.md = md; v.rq = rq; v.w = w; v.a = a;
        v.e_gnt = g; v.e_en = e; v.e_we = wb; v.e_addr = ea; v.e_rv = rv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Channel i sees address a + i*0x40 so the mux selection is observable.
    task automatic drive(input logic rst_n, input logic md, input logic [3:0] rq,
                         input logic [3:0] w, input logic [8:0] a);
        resetn = rst_n;
        mode   = md;
        req    = rq;
        we     = w;
        addr   = {a + 9'h0C0, a + 9'h080, a + 9'h040, a};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 9'h000);
        next_cycle();
        next_cycle();

        // single channel burst split by MAX_BURST
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 9'h000, 4'b0000, 0, 0, 9'h000, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h005, 4'b0000, 0, 0, 9'h000, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h005, 4'b0100, 1, 0, 9'h085, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h006, 4'b0100, 1, 0, 9'h086, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h007, 4'b0100, 1, 0, 9'h087, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h008, 4'b0100, 1, 0, 9'h088, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h009, 4'b0000, 0, 0, 9'h000, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h009, 4'b0100, 1, 0, 9'h089, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h00A, 4'b0100, 1, 0, 9'h08A, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 9'h00A, 4'b0100, 0, 0, 9'h08A, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 9'h000, 4'b0000, 0, 0, 9'h000, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 9'h000, 4'b0000, 0, 0, 9'h000, 4'b0000));
        // early release by ch1, ch2 writes while ch1's read returns
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 9'h011, 4'b0000, 0, 0, 9'h000, 4'b0000));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 9'h011, 4'b0010, 1, 0, 9'h051, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 9'h011, 4'b0010, 0, 0, 9'h051, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 9'h020, 4'b0000, 0, 0, 9'h000, 4'b0010));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 9'h020, 4'b0100, 1, 1, 9'h0A0, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 9'h021, 4'b0100, 1, 1, 9'h0A1, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 9'h021, 4'b0100, 0, 0, 9'h0A1, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 9'h000, 4'b0000, 0, 0, 9'h000, 4'b0000));
        // fixed priority with rr_ptr=3; mode flips back mid-grant
        tbl.push_back(mk(1, 4'b1010, 4'b0000, 9'h030, 4'b0000, 0, 0, 9'h000, 4'b0000));
        tbl.push_back(mk(1, 4'b1010, 4'b0000, 9'h030, 4'b0010, 1, 0, 9'h070, 4'b0000));
        tbl.push_back(mk(1, 4'b1010, 4'b0000, 9'h031, 4'b0010, 1, 0, 9'h071, 4'b0000));
        tbl.push_back(mk(1, 4'b1010, 4'b0000, 9'h032, 4'b0010, 1, 0, 9'h072, 4'b0010));
        tbl.push_back(mk(1, 4'b1010, 4'b0000, 9'h033, 4'b0010, 1, 0, 9'h073, 4'b0010));
        tbl.push_back(mk(1, 4'b1010, 4'b0000, 9'h034, 4'b0000, 0, 0, 9'h000, 4'b0010));
        tbl.push_back(mk(1, 4'b1010, 4'b0000, 9'h034, 4'b0010, 1, 0, 9'h074, 4'b0010));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 9'h035, 4'b0010, 1, 0, 9'h075, 4'b0000));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 9'h036, 4'b0010, 1, 0, 9'h076, 4'b0010));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 9'h037, 4'b0010, 1, 0, 9'h077, 4'b0010));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 9'h038, 4'b0000, 0, 0, 9'h000, 4'b0010));
        tbl.push_back(mk(0, 4'b1010, 4'b0000, 9'h038, 4'b1000, 1, 0, 9'h0F8, 4'b0010));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 9'h038, 4'b1000, 0, 0, 9'h0F8, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 9'h000, 4'b0000, 0, 0, 9'h000, 4'b1000));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 9'h000, 4'b0000, 0, 0, 9'h000, 4'b0000));

        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].md, tbl[i].rq, tbl[i].w, tbl[i].a);
            @(negedge clk);
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
            chk($sformatf("row%0d en_bram", i), 32'(en_bram), 32'(tbl[i].e_en));
            chk($sformatf("row%0d we_bram", i), 32'(we_bram), 32'(tbl[i].e_we));
            chk($sformatf("row%0d addr_bram", i), 32'(addr_bram), 32'(tbl[i].e_addr));
            chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(tbl[i].e_rv));
            next_cycle();
        end

        // round-robin from a fresh reset: order 0,1,2,3,0 with single bubbles
        drive(1'b0, 1'b0, 4'b1111, 4'b0000, 9'h000);
        next_cycle();
        drive(1'b1, 1'b0, 4'b1111, 4'b0000, 9'h000);
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk($sformatf("rr bubble%0d gnt", g), 32'(gnt), 32'd0);
            chk($sformatf("rr bubble%0d en", g), 32'(en_bram), 32'd0);
            next_cycle();
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                chk($sformatf("rr grant%0d beat%0d gnt", g, b), 32'(gnt), 32'd1 << (g % 4));
                chk($sformatf("rr grant%0d beat%0d en", g, b), 32'(en_bram), 32'd1);
                next_cycle();
            end
        end
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 9'h000);
        next_cycle();

        // ch0 writes 0xDEADBEEF to 0x1F, then reads it back
        drive(1'b1, 1'b0, 4'b0001, 4'b0001, 9'h01F);
        @(negedge clk);
        chk("rw idle gnt", 32'(gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rw wr gnt", 32'(gnt), 32'h1);
        chk("rw wr en", 32'(en_bram), 32'd1);
        chk("rw wr we", 32'(we_bram), 32'd1);
        chk("rw wr addr", 32'(addr_bram), 32'h1F);
        chk("rw wr din", din_bram, 32'hDEADBEEF);
        next_cycle();
        drive(1'b1, 1'b0, 4'b0001, 4'b0000, 9'h01F);
        @(negedge clk);
        chk("rw rd en", 32'(en_bram), 32'd1);
        chk("rw rd we", 32'(we_bram), 32'd0);
        chk("rw rd addr", 32'(addr_bram), 32'h1F);
        next_cycle();
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 9'h000);
        @(negedge clk);
        chk("rw no rvalid for write", 32'(rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rw rvalid", 32'(rvalid), 32'h1);
        chk("rw rdata", rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        chk("rw rvalid single pulse", 32'(rvalid), 32'd0);
        next_cycle();

        // reset during the 2nd beat of a ch2 read burst (rr_ptr was 1)
        drive(1'b1, 1'b0, 4'b0100, 4'b0000, 9'h002);
        next_cycle();
        @(negedge clk);
        chk("rst beat1 gnt", 32'(gnt), 32'h4);
        next_cycle();
        drive(1'b0, 1'b0, 4'b0100, 4'b0000, 9'h002);
        @(negedge clk);
        chk("rst beat2 en", 32'(en_bram), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 4'b1001, 4'b0000, 9'h002);
        @(negedge clk);
        chk("post-rst gnt", 32'(gnt), 32'd0);
        chk("post-rst en", 32'(en_bram), 32'd0);
        chk("post-rst rvalid", 32'(rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("post-rst rr_ptr0 gnt", 32'(gnt), 32'h1);
        chk("post-rst dropped read", 32'(rvalid), 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 9'h000);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
